// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe board writer: board geometry,
// cell encodings and the turn-sequencing FSM state encoding.
// Imported by ttt_cell_check and ttt_board_writer.
package ttt_pkg;

  localparam int CELLS = 9;   // board cells; cell i lives at board[2i+1:2i]
  localparam int POS_W = 4;   // width of a cell index

  localparam logic [1:0] CELL_EMPTY    = 2'b00;
  localparam logic [1:0] CELL_PLAYER   = 2'b01;
  localparam logic [1:0] CELL_COMPUTER = 2'b10;

  typedef enum logic [1:0] {
    P_TURN = 2'd0,
    C_TURN = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/ttt_cell_check.sv
// Purpose : decides whether the move of the side to play is legal and
//           produces a one-hot write enable for the target cell.
// Latency : combinational.  Backpressure: none.
// Ports   : board (packed cells), player_pos / computer_pos (requested
//           indices), turn (0 = player, 1 = computer) selects which index is
//           examined; legal and we (one-hot, all zero when illegal) out.
module ttt_cell_check
  import ttt_pkg::*;
(
  input  logic [2*CELLS-1:0] board,
  input  logic [POS_W-1:0]   player_pos,
  input  logic [POS_W-1:0]   computer_pos,
  input  logic               turn,
  output logic               legal,
  output logic [CELLS-1:0]   we
);

  logic [POS_W-1:0] pos;

  always_comb begin
    pos   = turn ? computer_pos : player_pos;
    legal = 1'b0;
    we    = '0;
    // Indices beyond the board never match any i, so they fall out as illegal.
    for (int i = 0; i < CELLS; i++) begin
      if (pos == POS_W'(i) && board[2*i +: 2] == CELL_EMPTY) begin
        legal = 1'b1;
        we[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ttt_board_writer.sv
// Purpose : holds the 3x3 board, enforces turn order, writes legal moves and
//           stops accepting moves once the game is won or the board is full.
// Latency : one cycle from request to updated board / move_ack / illegal.
// Backpressure: none; a request may be presented every cycle and is checked
//           against the board as updated by the previous edge.
// Ports   : clk, rst_n (async, active low), new_game (sync clear),
//           player_req/player_pos, computer_req/computer_pos, game_over in;
//           board, turn, move_ack, illegal, board_full, done out (all
//           registered).  Defining TTT_MOVE_COUNT_EN adds move_count[3:0]
//           and derives board_full from the move count.
module ttt_board_writer
  import ttt_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               new_game,
  input  logic               player_req,
  input  logic [POS_W-1:0]   player_pos,
  input  logic               computer_req,
  input  logic [POS_W-1:0]   computer_pos,
  input  logic               game_over,
  output logic [2*CELLS-1:0] board,
  output logic               turn,
  output logic               move_ack,
  output logic               illegal,
  output logic               board_full,
  output logic               done
`ifdef TTT_MOVE_COUNT_EN
  ,output logic [3:0]        move_count
`endif
);

  state_t             state;
  logic               legal;
  logic [CELLS-1:0]   we;
  logic               req;
  logic [1:0]         code;
  logic [2*CELLS-1:0] board_next;
  logic               full_next;

  ttt_cell_check u_cell_check (
    .board        (board),
    .player_pos   (player_pos),
    .computer_pos (computer_pos),
    .turn         (state == C_TURN),
    .legal        (legal),
    .we           (we)
  );

  // Only the request of the side to move is considered; the other is ignored.
  always_comb begin
    req        = 1'b0;
    code       = CELL_PLAYER;
    board_next = board;
    full_next  = 1'b1;
    case (state)
      P_TURN:  req = player_req;
      C_TURN:  begin req = computer_req; code = CELL_COMPUTER; end
      default: req = 1'b0;
    endcase
    for (int i = 0; i < CELLS; i++) begin
      if (we[i]) board_next[2*i +: 2] = code;
      if (board_next[2*i +: 2] == CELL_EMPTY) full_next = 1'b0;
    end
`ifdef TTT_MOVE_COUNT_EN
    // Every accepted move fills exactly one empty cell, so the ninth accepted
    // move is the one that fills the board.
    full_next = (move_count == 4'd8);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= P_TURN;
      board      <= '0;
      turn       <= 1'b0;
      move_ack   <= 1'b0;
      illegal    <= 1'b0;
      board_full <= 1'b0;
      done       <= 1'b0;
`ifdef TTT_MOVE_COUNT_EN
      move_count <= 4'd0;
`endif
    end else begin
      move_ack <= 1'b0;
      illegal  <= 1'b0;
      if (new_game) begin
        state      <= P_TURN;
        board      <= '0;
        turn       <= 1'b0;
        board_full <= 1'b0;
        done       <= 1'b0;
`ifdef TTT_MOVE_COUNT_EN
        move_count <= 4'd0;
`endif
      end else begin
        case (state)
          P_TURN, C_TURN: begin
            if (game_over) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (req) begin
              if (legal) begin
                board      <= board_next;
                move_ack   <= 1'b1;
                board_full <= full_next;
`ifdef TTT_MOVE_COUNT_EN
                move_count <= move_count + 4'd1;
`endif
                if (full_next) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else if (state == P_TURN) begin
                  state <= C_TURN;
                  turn  <= 1'b1;
                end else begin
                  state <= P_TURN;
                  turn  <= 1'b0;
                end
              end else begin
                illegal <= 1'b1;
              end
            end
          end
          default: ; // DONE: only new_game or reset leaves
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ttt_board_writer.sv
// Directed bench for ttt_board_writer: turn order, illegal moves, full board,
// game_over priority, new_game and asynchronous reset.
module tb_ttt_board_writer;
  import ttt_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               new_game;
  logic               player_req;
  logic [POS_W-1:0]   player_pos;
  logic               computer_req;
  logic [POS_W-1:0]   computer_pos;
  logic               game_over;
  logic [2*CELLS-1:0] board;
  logic               turn;
  logic               move_ack;
  logic               illegal;
  logic               board_full;
  logic               done;
`ifdef TTT_MOVE_COUNT_EN
  logic [3:0]         move_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ttt_board_writer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .new_game     (new_game),
    .player_req   (player_req),
    .player_pos   (player_pos),
    .computer_req (computer_req),
    .computer_pos (computer_pos),
    .game_over    (game_over),
    .board        (board),
    .turn         (turn),
    .move_ack     (move_ack),
    .illegal      (illegal),
    .board_full   (board_full),
    .done         (done)
`ifdef TTT_MOVE_COUNT_EN
    ,.move_count  (move_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    new_game = 0; player_req = 0; computer_req = 0; game_over = 0;
    player_pos = '0; computer_pos = '0;
  endtask

  task automatic check_status(input string tag, input logic [17:0] b, input logic t,
                              input logic ack, input logic ill, input logic full, input logic dn);
    check({tag, ".board"}, 32'(board), 32'(b));
    check({tag, ".turn"}, 32'(turn), 32'(t));
    check({tag, ".ack"}, 32'(move_ack), 32'(ack));
    check({tag, ".illegal"}, 32'(illegal), 32'(ill));
    check({tag, ".full"}, 32'(board_full), 32'(full));
    check({tag, ".done"}, 32'(done), 32'(dn));
  endtask

  // Fill order after player@4 and computer@0; alternates P,C,... ending on P.
  int fill_pos [7] = '{1, 2, 3, 5, 6, 7, 8};

  initial begin
    logic [17:0] exp_board;
    logic        exp_turn;

    idle();
    rst_n = 0;
    #2;
    check_status("reset", 18'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;

    // Player takes the centre.
    player_req = 1; player_pos = 4;
    tick();
    idle();
    check_status("p4", 18'h00100, 1, 1, 0, 0, 0);
    tick();
    check("p4.ack_clears", 32'(move_ack), 32'd0);

    // Computer tries the occupied centre, then cell 0.
    computer_req = 1; computer_pos = 4;
    tick();
    check_status("c4_occ", 18'h00100, 1, 0, 1, 0, 0);
    computer_pos = 0;
    tick();
    idle();
    check_status("c0", 18'h00102, 0, 1, 0, 0, 0);

    // Out-of-range index, then an out-of-turn computer request.
    player_req = 1; player_pos = 12;
    tick();
    idle();
    check_status("p12", 18'h00102, 0, 0, 1, 0, 0);
    computer_req = 1; computer_pos = 1;
    tick();
    idle();
    check_status("c_oot", 18'h00102, 0, 0, 0, 0, 0);

    // Back-to-back moves filling the board; both strobes held high throughout,
    // so the out-of-turn one must be ignored each cycle.
    exp_board = 18'h00102;
    exp_turn  = 0;
    player_req = 1; computer_req = 1;
    for (int k = 0; k < 7; k++) begin
      player_pos   = POS_W'(fill_pos[k]);
      computer_pos = POS_W'(fill_pos[k]);
      tick();
      exp_board[2*fill_pos[k] +: 2] = exp_turn ? CELL_COMPUTER : CELL_PLAYER;
      exp_turn = ~exp_turn;
      check("fill.ack", 32'(move_ack), 32'd1);
      check("fill.board", 32'(board), 32'(exp_board));
      if (k < 6) begin
        check("fill.turn", 32'(turn), 32'(exp_turn));
        check("fill.notfull", 32'(board_full), 32'd0);
        check("fill.notdone", 32'(done), 32'd0);
      end
    end
    check("full.board_const", 32'(board), 32'h19966);
    check("full.full", 32'(board_full), 32'd1);
    check("full.done", 32'(done), 32'd1);
    // Requests in DONE: no ack, no illegal.
    player_pos = 0; computer_pos = 15;
    tick();
    idle();
    check("done.ack", 32'(move_ack), 32'd0);
    check("done.illegal", 32'(illegal), 32'd0);
    check("done.board", 32'(board), 32'h19966);

    // new_game clears everything.
    new_game = 1;
    tick();
    idle();
    check_status("ng1", 18'h0, 0, 0, 0, 0, 0);

    // game_over beats a legal move in the same cycle.
    game_over = 1; player_req = 1; player_pos = 4;
    tick();
    idle();
    check_status("gover", 18'h0, 0, 0, 0, 0, 1);
    // new_game beats a same-cycle request.
    new_game = 1; player_req = 1; player_pos = 2;
    tick();
    idle();
    check_status("ng2", 18'h0, 0, 0, 0, 0, 0);

    // Short game, then an asynchronous reset between edges.
    player_req = 1; player_pos = 4;
    tick();
    idle();
`ifdef TTT_MOVE_COUNT_EN
    check("mc1", 32'(move_count), 32'd1);
`endif
    computer_req = 1; computer_pos = 0;
    tick();
    idle();
`ifdef TTT_MOVE_COUNT_EN
    check("mc2", 32'(move_count), 32'd2);
`endif
    player_req = 1; player_pos = 15;
    tick();
    idle();
    check("p15.illegal", 32'(illegal), 32'd1);
`ifdef TTT_MOVE_COUNT_EN
    check("mc_ill", 32'(move_count), 32'd2);
`endif
    player_req = 1; player_pos = 2;
    tick();
    idle();
    check("pre_rst.board", 32'(board), 32'h00112);
`ifdef TTT_MOVE_COUNT_EN
    check("mc3", 32'(move_count), 32'd3);
`endif
    #2;
    rst_n = 0;
    #1;
    check_status("arst", 18'h0, 0, 0, 0, 0, 0);
`ifdef TTT_MOVE_COUNT_EN
    check("arst.mc", 32'(move_count), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish within 20000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ttt_board_writer.md
Name: ttt_board_writer

Overview:
- Holds the 3x3 tic-tac-toe board and writes moves into it. Player cells are encoded 01, computer cells 10, and empty cells 00.
- It is the producing end of the board-position interface. Its packed board output drives the win-detection instances, and their combined win flag returns here as game_over.
- It enforces turn order, rejects illegal moves and stops accepting moves when the game ends.

Parameters:
- CELLS, 9, number of board cells. Cell i occupies board[2i+1:2i].
- POS_W, 4, width of the cell-index inputs.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- new_game  in  1  synchronous clear of the board and all state.
- player_req  in  1  player move strobe, sampled each cycle.
- player_pos  in  POS_W  cell index for the player move.
- computer_req  in  1  computer move strobe.
- computer_pos  in  POS_W  cell index for the computer move.
- game_over  in  1  win indication from the winner-detection logic.
- board  out  2*CELLS  packed board state.
- turn  out  1  0 = player to move, 1 = computer to move.
- move_ack  out  1  one-cycle pulse: a move was written.
- illegal  out  1  one-cycle pulse: a move was rejected.
- board_full  out  1  all cells are non-empty.
- done  out  1  game has ended; no further moves are accepted.

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - board = 0, state = P_TURN, turn = 0
  - move_ack = 0, illegal = 0, done = 0, board_full = 0
- All outputs are registered.
- States:
  - P_TURN: turn = 0.
  - C_TURN: turn = 1.
  - DONE: done = 1.
- Priority each cycle, highest first:
  1. new_game
  2. game_over
  3. the move request belonging to the current turn
- new_game, in any state: at the next edge board = 0, state = P_TURN, and move_ack, illegal and done are 0. Any request in the same cycle is dropped.
- game_over high in P_TURN or C_TURN: go to DONE at the next edge. A same-cycle request is ignored: no write, no ack, no illegal.
- Move in P_TURN (player_req = 1):
  - Legal when player_pos < CELLS and the target cell is 00.
  - Legal move: write 01 to the cell and pulse move_ack in the following cycle, when the new board is also visible. Go to C_TURN, or to DONE if the board becomes full.
  - Otherwise: illegal = 1 for one cycle; board and state are unchanged.
- Move in C_TURN: same rules using computer_req / computer_pos, writing 10. Next state is P_TURN, or DONE if the board becomes full.
- Out-of-turn requests (computer_req in P_TURN, player_req in C_TURN) are silently ignored, including when both requests arrive together.
- DONE: all requests are ignored with no ack and no illegal. Only new_game or reset exits DONE.
- board_full is registered and true when all nine cells are non-zero after the current write. An illegal 11 code can never be written.
- Indices 9..15 are always illegal.
- Back-to-back requests every cycle are allowed; each one is evaluated against the board updated by the previous edge.

Optional Feature:
- Macro: TTT_MOVE_COUNT_EN.
- When defined:
  - Adds output move_count [3:0]. It is reset to 0, cleared by new_game, and incremented by exactly 1 on each accepted move.
  - board_full is then derived as move_count == 9 (registered).
- When undefined:
  - No move_count port.
  - board_full is computed from the board cells as described above.
- Observable board_full timing is identical in both builds.

Decomposition:
- Shared package ttt_pkg holds:
  - Cell codes: CELL_EMPTY = 2'b00, CELL_PLAYER = 2'b01, CELL_COMPUTER = 2'b10.
  - CELLS = 9.
  - The FSM state encoding (P_TURN, C_TURN, DONE).
- One natural sub-module, ttt_cell_check. It is combinational and takes board, pos and the current turn. It returns legal and a one-hot write-enable vector.

Test Plan:
- Reset, then player_req with pos = 4 → next cycle board[9:8] = 01, move_ack = 1, turn = 1.
- Computer writes pos 4 into an occupied cell → illegal pulse, board unchanged, turn stays 1. Then pos 0 → board[1:0] = 10, turn = 0.
- player_pos = 12 → illegal = 1, no write. computer_req while turn = 0 → nothing happens.
- Alternating legal moves filling all 9 cells with game_over low → board_full = 1 and done = 1 after the 9th ack. A further request produces no ack and no illegal.
- game_over asserted in the same cycle as a legal player_req → no write, done = 1 next cycle. new_game then gives board = 0 and turn = 0.
- rst_n dropped mid-game, asynchronously between edges → board = 0 immediately. With TTT_MOVE_COUNT_EN, move_count tracks accepted moves 0→3 over three legal moves and is unaffected by illegal ones.
